// File: rtl/stage4_mem_access_if.sv
// Execute-to-writeback bundle for the memory-access stage: upstream operands,
// the data-memory req/ack bus, the stall line and the register-file write-back.
interface stage4_mem_access_if;
  logic [15:0] res_out;
  logic [15:0] store_data;
  logic        mem_read;
  logic        mem_write;
  logic        mem_to_reg;
  logic        reg_write_in;
  logic [3:0]  dest_reg;

  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_rdata;
  logic        mem_ack;

  logic        stall;
  logic [15:0] wb_data;
  logic [3:0]  wb_reg;
  logic        wb_write;
  logic        mem_fault;

  // Driver side: upstream pipeline plus data memory.
  modport master (
    output res_out, store_data, mem_read, mem_write, mem_to_reg, reg_write_in, dest_reg,
    output mem_rdata, mem_ack,
    input  mem_addr, mem_wdata, mem_req, mem_we,
    input  stall, wb_data, wb_reg, wb_write, mem_fault
  );

  // Stage side.
  modport slave (
    input  res_out, store_data, mem_read, mem_write, mem_to_reg, reg_write_in, dest_reg,
    input  mem_rdata, mem_ack,
    output mem_addr, mem_wdata, mem_req, mem_we,
    output stall, wb_data, wb_reg, wb_write, mem_fault
  );
endinterface

// File: rtl/stage4_mem_access.sv
// Memory-access pipeline stage: passes ALU results through, or runs one
// req/ack data-memory transaction with a timeout, stalling upstream meanwhile.
//
// state | meaning
// IDLE  | pass-through; a load/store here stalls and launches a request
// REQ   | MemReq high, waiting for MemAck or the timeout
// DONE  | write-back visible for one cycle, upstream released
module stage4_mem_access #(
  parameter int unsigned TIMEOUT = 15
) (
  input logic              clk_i,
  input logic              rst_n_i,
  stage4_mem_access_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [15:0] mem_wdata_q, mem_wdata_d;
  logic        mem_we_q, mem_we_d;
  logic [15:0] wb_data_q, wb_data_d;
  logic [3:0]  wb_reg_q, wb_reg_d;
  logic        wb_write_q, wb_write_d;
  logic        fault_q, fault_d;
  logic [3:0]  dest_q, dest_d;
  logic        regwr_q, regwr_d;
  logic        mtr_q, mtr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        mem_op;

  assign mem_op = bus.mem_read | bus.mem_write;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      wb_data_q   <= '0;
      wb_reg_q    <= '0;
      wb_write_q  <= 1'b0;
      fault_q     <= 1'b0;
      dest_q      <= '0;
      regwr_q     <= 1'b0;
      mtr_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      wb_data_q   <= wb_data_d;
      wb_reg_q    <= wb_reg_d;
      wb_write_q  <= wb_write_d;
      fault_q     <= fault_d;
      dest_q      <= dest_d;
      regwr_q     <= regwr_d;
      mtr_q       <= mtr_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = mem_we_q;
    wb_data_d   = wb_data_q;
    wb_reg_d    = wb_reg_q;
    wb_write_d  = wb_write_q;
    fault_d     = fault_q;
    dest_d      = dest_q;
    regwr_d     = regwr_q;
    mtr_d       = mtr_q;
    cnt_d       = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (mem_op) begin
          // A load+store combination falls out as a store since only MemWrite is latched.
          mem_addr_d  = bus.res_out;
          mem_wdata_d = bus.store_data;
          mem_we_d    = bus.mem_write;
          dest_d      = bus.dest_reg;
          regwr_d     = bus.reg_write_in;
          mtr_d       = bus.mem_to_reg;
          cnt_d       = '0;
          wb_write_d  = 1'b0;
          state_d     = REQ;
        end else begin
          wb_data_d  = bus.res_out;
          wb_reg_d   = bus.dest_reg;
          wb_write_d = bus.reg_write_in;
        end
      end
      REQ: begin
        cnt_d = cnt_q + 8'd1;
        if (bus.mem_ack) begin
          // The latched ResOut is the address register, so reuse it for non-load write-back.
          wb_data_d  = mtr_q ? bus.mem_rdata : mem_addr_q;
          wb_reg_d   = dest_q;
          wb_write_d = regwr_q;
          state_d    = DONE;
        end else if (cnt_q == CNT_LAST) begin
          fault_d    = 1'b1;
          wb_write_d = 1'b0;
          state_d    = DONE;
        end
      end
      DONE: begin
        wb_write_d = 1'b0;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_req   = (state_q == REQ);
  // Gated by reset so a held load/store on the inputs cannot keep Stall high during reset.
  assign bus.stall     = rst_n_i & (((state_q == IDLE) & mem_op) | (state_q == REQ));
  assign bus.wb_data   = wb_data_q;
  assign bus.wb_reg    = wb_reg_q;
  assign bus.wb_write  = wb_write_q;
  assign bus.mem_fault = fault_q;

endmodule

// File: tb/tb_stage4_mem_access.sv
// Directed bench for stage4_mem_access: write-back scoreboard plus cycle checks
// on the memory handshake, stall, timeout fault and asynchronous reset.
module tb_stage4_mem_access;

  localparam int TIMEOUT = 15;

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  rg;
  } wb_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic exp_fault;
  wb_t  sb_q[$];

  stage4_mem_access_if bus();

  stage4_mem_access #(.TIMEOUT(TIMEOUT)) dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Write-back monitor: every WBWrite pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.wb_write === 1'b1) begin
      chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        wb_t e;
        e = sb_q.pop_front();
        chk("sb_wb_data", bus.wb_data, e.data);
        chk("sb_wb_reg", bus.wb_reg, e.rg);
      end
    end
  end

  task automatic alu(input logic [15:0] res, input logic [3:0] dst, input logic rw);
    bus.mem_read     = 1'b0;
    bus.mem_write    = 1'b0;
    bus.mem_to_reg   = 1'b0;
    bus.res_out      = res;
    bus.store_data   = 16'h5555;
    bus.dest_reg     = dst;
    bus.reg_write_in = rw;
    #1;
    chk("alu_stall", bus.stall, 1'b0);
    if (rw) sb_q.push_back('{data: res, rg: dst});
    tick();
    chk("alu_wb_data", bus.wb_data, res);
    chk("alu_wb_reg", bus.wb_reg, dst);
    chk("alu_wb_write", bus.wb_write, rw);
    chk("alu_mem_req", bus.mem_req, 1'b0);
  endtask

  // ack_k = REQ cycle in which memory acks (1-based); 0 means never.
  task automatic mem_op(input logic rd, input logic wr, input logic mtr, input logic rw,
                        input logic [15:0] addr, input logic [15:0] sdata,
                        input logic [3:0] dst, input int ack_k, input logic [15:0] rdata);
    int  reqs;
    int  stalls;
    bit  acked;
    logic [15:0] exp_wb;
    bus.mem_read     = rd;
    bus.mem_write    = wr;
    bus.mem_to_reg   = mtr;
    bus.res_out      = addr;
    bus.store_data   = sdata;
    bus.dest_reg     = dst;
    bus.reg_write_in = rw;
    #1;
    chk("issue_stall", bus.stall, 1'b1);
    chk("issue_req", bus.mem_req, 1'b0);
    stalls = int'(bus.stall);
    exp_wb = mtr ? rdata : addr;
    if (rw && ack_k != 0) sb_q.push_back('{data: exp_wb, rg: dst});
    tick();
    reqs  = 0;
    acked = 1'b0;
    for (int k = 1; k <= TIMEOUT && !acked; k++) begin
      chk("req_mem_req", bus.mem_req, 1'b1);
      chk("req_mem_addr", bus.mem_addr, addr);
      chk("req_mem_we", bus.mem_we, wr);
      chk("req_mem_wdata", bus.mem_wdata, sdata);
      chk("req_wb_write", bus.wb_write, 1'b0);
      reqs++;
      stalls += int'(bus.stall);
      if (k == ack_k) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = rdata;
        acked         = 1'b1;
      end
      tick();
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 16'h0000;
    end
    chk("req_cycles", reqs, (ack_k != 0) ? ack_k : TIMEOUT);
    chk("stall_cycles", stalls, reqs + 1);
    if (ack_k == 0) exp_fault = 1'b1;
    chk("done_mem_req", bus.mem_req, 1'b0);
    chk("done_stall", bus.stall, 1'b0);
    chk("done_wb_write", bus.wb_write, rw && (ack_k != 0));
    chk("done_fault", bus.mem_fault, exp_fault);
    if (rw && ack_k != 0) begin
      chk("done_wb_data", bus.wb_data, exp_wb);
      chk("done_wb_reg", bus.wb_reg, dst);
    end
    tick();
    chk("post_wb_write", bus.wb_write, 1'b0);
    chk("post_mem_req", bus.mem_req, 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_fault = 1'b0;
    rst_n = 1'b0;
    bus.res_out = '0; bus.store_data = '0; bus.mem_read = 1'b0; bus.mem_write = 1'b0;
    bus.mem_to_reg = 1'b0; bus.reg_write_in = 1'b0; bus.dest_reg = '0;
    bus.mem_rdata = '0; bus.mem_ack = 1'b0;
    tick();
    bus.mem_read = 1'b1;
    tick();
    chk("rst_stall", bus.stall, 1'b0);
    chk("rst_mem_req", bus.mem_req, 1'b0);
    chk("rst_wb_write", bus.wb_write, 1'b0);
    chk("rst_wb_data", bus.wb_data, 16'h0000);
    chk("rst_mem_addr", bus.mem_addr, 16'h0000);
    chk("rst_fault", bus.mem_fault, 1'b0);
    bus.mem_read = 1'b0;
    #2 rst_n = 1'b1;

    alu(16'h0011, 4'd1, 1'b1);
    alu(16'h0022, 4'd2, 1'b1);
    alu(16'h0033, 4'd3, 1'b1);
    alu(16'h0000, 4'd0, 1'b0);

    mem_op(1'b1, 1'b0, 1'b1, 1'b1, 16'h1234, 16'h0000, 4'd5, 2, 16'hBEEF);
    mem_op(1'b0, 1'b1, 1'b0, 1'b0, 16'h00F0, 16'hA5A5, 4'd0, 1, 16'h0000);
    mem_op(1'b1, 1'b1, 1'b0, 1'b1, 16'h0040, 16'h7777, 4'd6, 1, 16'h9999);
    mem_op(1'b1, 1'b0, 1'b1, 1'b1, 16'h2000, 16'h0000, 4'd7, 0, 16'h0000);

    alu(16'h0044, 4'd4, 1'b1);
    alu(16'h0055, 4'd8, 1'b1);
    chk("fault_sticky", bus.mem_fault, 1'b1);

    bus.mem_ack = 1'b1;
    bus.mem_rdata = 16'hDEAD;
    alu(16'h0066, 4'd9, 1'b1);
    alu(16'h0077, 4'd10, 1'b1);
    bus.mem_ack = 1'b0;
    bus.mem_rdata = 16'h0000;

    // Load left outstanding, then reset lands in its fourth REQ cycle.
    bus.mem_read = 1'b1; bus.mem_write = 1'b0; bus.mem_to_reg = 1'b1;
    bus.res_out = 16'h3000; bus.dest_reg = 4'd11; bus.reg_write_in = 1'b1;
    #1;
    tick();
    for (int k = 1; k <= 4; k++) begin
      chk("rr_mem_req", bus.mem_req, 1'b1);
      if (k < 4) tick();
    end
    rst_n = 1'b0;
    exp_fault = 1'b0;
    #1;
    chk("rr_mem_req_low", bus.mem_req, 1'b0);
    chk("rr_stall_low", bus.stall, 1'b0);
    chk("rr_wb_write_low", bus.wb_write, 1'b0);
    chk("rr_fault_clr", bus.mem_fault, exp_fault);
    chk("rr_wb_data", bus.wb_data, 16'h0000);
    tick();
    bus.mem_read = 1'b0; bus.mem_to_reg = 1'b0; bus.reg_write_in = 1'b0;
    #2 rst_n = 1'b1;
    alu(16'h0088, 4'd12, 1'b1);
    alu(16'h0099, 4'd13, 1'b1);
    chk("rr_fault_after", bus.mem_fault, 1'b0);

    alu(16'h0000, 4'd0, 1'b0);
    tick();
    chk("end_wb_write", bus.wb_write, 1'b0);
    chk("sb_drained", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
